isp_wbgain: RTL and testbench



---
 rtl/isp_wbgain.sv | 184 ++++++++++++++++++
 tb/tb_isp_wbgain.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_wbgain.sv
`default_nettype none
// ============================================================================
//  Module   : isp_wbgain
//  Purpose  : Bayer-domain white-balance gain. Tracks the Bayer phase of the
//             incoming raw stream, applies a per-channel (R/G/B) unsigned
//             fixed-point gain with round-half-up and saturation, and delays
//             href/vsync to match the 3-cycle data pipeline. Gains are
//             shadowed on the vsync rising edge so a frame never tears.
//  Options  : ISP_WBGAIN_STAT_EN adds per-channel pre-gain pixel sums,
//             published once per frame on the vsync rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module isp_wbgain #(
  parameter int BITS      = 8,
  parameter int BAYER     = 0,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6,
  parameter int STAT_W    = 32
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              in_href,
  input  logic              in_vsync,
  input  logic [BITS-1:0]   in_raw,
  input  logic [GAIN_W-1:0] r_gain,
  input  logic [GAIN_W-1:0] g_gain,
  input  logic [GAIN_W-1:0] b_gain,
  output logic              out_href,
  output logic              out_vsync,
`ifdef ISP_WBGAIN_STAT_EN
  output logic              stat_valid,
  output logic [STAT_W-1:0] stat_r_sum,
  output logic [STAT_W-1:0] stat_g_sum,
  output logic [STAT_W-1:0] stat_b_sum,
`endif
  output logic [BITS-1:0]   out_raw
);

  localparam int                c_prod_w    = BITS + GAIN_W;
  localparam logic [1:0]        c_bayer_fmt = 2'(BAYER);
  localparam logic [GAIN_W-1:0] c_unity     = GAIN_W'(1) << GAIN_FRAC;
  localparam logic [c_prod_w:0] c_round     = (c_prod_w + 1)'(1) << (GAIN_FRAC - 1);
  localparam logic [BITS-1:0]   c_pix_max   = '1;

  // Reject parameter sets the rounding/shift arithmetic cannot represent.
  if (GAIN_FRAC < 1 || GAIN_FRAC >= GAIN_W || STAT_W < 1) begin : g_param_check
    $error("isp_wbgain: illegal GAIN_FRAC/GAIN_W/STAT_W combination");
  end

  logic                r_vsync_prev;
  logic [GAIN_W-1:0]   r_sh_r, r_sh_g, r_sh_b;
  logic                r_odd_pix, r_odd_line;
  logic [2:0]          r_href_dly, r_vsync_dly;
  logic [BITS-1:0]     r_pix_s1;
  logic [GAIN_W-1:0]   r_gain_s1;
  logic [c_prod_w-1:0] r_prod_s2;
  logic [BITS-1:0]     r_out_s3;

  logic                w_vs_rise, w_href_fall;
  logic [1:0]          w_fmt;
  logic [GAIN_W-1:0]   w_gain_sel;
  logic [c_prod_w:0]   w_rounded, w_shifted;
  logic [BITS-1:0]     w_sat;

  // r_href_dly[0] is last cycle's href, so it doubles as the edge detector.
  assign w_vs_rise   = in_vsync & ~r_vsync_prev;
  assign w_href_fall = r_href_dly[0] & ~in_href;
  assign w_fmt       = c_bayer_fmt ^ {r_odd_line, r_odd_pix};

  // Channel select: 0 is R, 3 is B, both G phases share one gain.
  always_comb begin
    w_gain_sel = r_sh_g;
    case (w_fmt)
      2'd0:    w_gain_sel = r_sh_r;
      2'd3:    w_gain_sel = r_sh_b;
      default: w_gain_sel = r_sh_g;
    endcase
  end

  // Round half up, drop the fraction, clamp to the pixel range.
  always_comb begin
    w_rounded = {1'b0, r_prod_s2} + c_round;
    w_shifted = w_rounded >> GAIN_FRAC;
    w_sat     = (w_shifted > (c_prod_w + 1)'(c_pix_max)) ? c_pix_max : w_shifted[BITS-1:0];
  end

  // Frame-level state: vsync edge detect, gain shadows, Bayer phase.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vsync_prev <= 1'b0;
      r_sh_r       <= c_unity;
      r_sh_g       <= c_unity;
      r_sh_b       <= c_unity;
      r_odd_pix    <= 1'b0;
      r_odd_line   <= 1'b0;
    end else begin
      r_vsync_prev <= in_vsync;
      if (w_vs_rise) begin
        r_sh_r <= r_gain;
        r_sh_g <= g_gain;
        r_sh_b <= b_gain;
      end
      r_odd_pix <= in_href ? ~r_odd_pix : 1'b0;
      // vsync clear takes priority over a coincident line-end toggle.
      if (in_vsync)
        r_odd_line <= 1'b0;
      else if (w_href_fall)
        r_odd_line <= ~r_odd_line;
    end
  end

  // Three-stage data pipeline with matching sync delay line.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_href_dly  <= '0;
      r_vsync_dly <= '0;
      r_pix_s1    <= '0;
      r_gain_s1   <= '0;
      r_prod_s2   <= '0;
      r_out_s3    <= '0;
    end else begin
      r_href_dly  <= {r_href_dly[1:0], in_href};
      r_vsync_dly <= {r_vsync_dly[1:0], in_vsync};
      r_pix_s1    <= in_raw;
      r_gain_s1   <= w_gain_sel;
      r_prod_s2   <= c_prod_w'(r_pix_s1) * c_prod_w'(r_gain_s1);
      // Mask here so data and out_href leave the same register stage.
      r_out_s3    <= r_href_dly[1] ? w_sat : '0;
    end
  end

  assign out_href  = r_href_dly[2];
  assign out_vsync = r_vsync_dly[2];
  assign out_raw   = r_out_s3;

`ifdef ISP_WBGAIN_STAT_EN
  logic [STAT_W-1:0] r_acc_r, r_acc_g, r_acc_b;
  logic [STAT_W-1:0] w_pix_ext, w_base_r, w_base_g, w_base_b;
  logic              w_add_r, w_add_g, w_add_b;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
  endfunction

  // A vsync-rise pixel starts the new frame, so accumulate onto a zero base.
  always_comb begin
    w_pix_ext = STAT_W'(in_raw);
    w_add_r   = in_href && (w_fmt == 2'd0);
    w_add_b   = in_href && (w_fmt == 2'd3);
    w_add_g   = in_href && (w_fmt == 2'd1 || w_fmt == 2'd2);
    w_base_r  = w_vs_rise ? '0 : r_acc_r;
    w_base_g  = w_vs_rise ? '0 : r_acc_g;
    w_base_b  = w_vs_rise ? '0 : r_acc_b;
  end

  // Per-channel saturating sums, published and restarted on vsync rise.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_acc_r    <= '0;
      r_acc_g    <= '0;
      r_acc_b    <= '0;
      stat_r_sum <= '0;
      stat_g_sum <= '0;
      stat_b_sum <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= w_vs_rise;
      if (w_vs_rise) begin
        stat_r_sum <= r_acc_r;
        stat_g_sum <= r_acc_g;
        stat_b_sum <= r_acc_b;
      end
      r_acc_r <= w_add_r ? sat_add(w_base_r, w_pix_ext) : w_base_r;
      r_acc_g <= w_add_g ? sat_add(w_base_g, w_pix_ext) : w_base_g;
      r_acc_b <= w_add_b ? sat_add(w_base_b, w_pix_ext) : w_base_b;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_isp_wbgain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_isp_wbgain
//  Purpose  : Self-checking bench for isp_wbgain. Two instances (BAYER 0 and
//             BAYER 3) share one stimulus stream; a frame-level reference
//             model predicts every output cycle, and directed frames pin
//             literal values. Set ISP_WBGAIN_STAT_EN to cover statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_isp_wbgain;

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic       href = 1'b0, vsync = 1'b0;
  logic [7:0] raw  = '0;
  logic [7:0] rg = 8'd64, gg = 8'd64, bg = 8'd64;

  logic       oh_a, ov_a, oh_b, ov_b;
  logic [7:0] or_a, or_b;

`ifdef ISP_WBGAIN_STAT_EN
  logic        sv_a, sv_b;
  logic [31:0] sr_a, sg_a, sb_a, sr_b, sg_b, sb_b;
`endif

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 pclk = ~pclk;

  isp_wbgain #(.BITS(8), .BAYER(0), .GAIN_W(8), .GAIN_FRAC(6), .STAT_W(32)) dut_a (
    .pclk(pclk), .rst(rst), .in_href(href), .in_vsync(vsync), .in_raw(raw),
    .r_gain(rg), .g_gain(gg), .b_gain(bg),
    .out_href(oh_a), .out_vsync(ov_a),
`ifdef ISP_WBGAIN_STAT_EN
    .stat_valid(sv_a), .stat_r_sum(sr_a), .stat_g_sum(sg_a), .stat_b_sum(sb_a),
`endif
    .out_raw(or_a));

  isp_wbgain #(.BITS(8), .BAYER(3), .GAIN_W(8), .GAIN_FRAC(6), .STAT_W(32)) dut_b (
    .pclk(pclk), .rst(rst), .in_href(href), .in_vsync(vsync), .in_raw(raw),
    .r_gain(rg), .g_gain(gg), .b_gain(bg),
    .out_href(oh_b), .out_vsync(ov_b),
`ifdef ISP_WBGAIN_STAT_EN
    .stat_valid(sv_b), .stat_r_sum(sr_b), .stat_g_sum(sg_b), .stat_b_sum(sb_b),
`endif
    .out_raw(or_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Column = href-high cycles since href last dropped; line = href falls since vsync.
  int        m_col = 0, m_line = 0;
  bit        m_prev_vs = 0, m_prev_href = 0;
  int        m_sh[3] = '{64, 64, 64};
  int        bayer_of[2] = '{0, 3};
  int        ex_d[2][3];
  bit        ex_h[2][3], ex_v[2][3];

  function automatic int gained(input int pix, input int gain);
    int v;
    v = (pix * gain + 32) / 64;
    return (v > 255) ? 255 : v;
  endfunction

  always @(posedge pclk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int s = 0; s < 3; s++) begin
          ex_d[k][s] = 0; ex_h[k][s] = 0; ex_v[k][s] = 0;
        end
      m_sh = '{64, 64, 64};
      m_col = 0; m_line = 0; m_prev_vs = 0; m_prev_href = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int fmt, g;
        for (int s = 2; s > 0; s--) begin
          ex_d[k][s] = ex_d[k][s-1]; ex_h[k][s] = ex_h[k][s-1]; ex_v[k][s] = ex_v[k][s-1];
        end
        fmt = bayer_of[k] ^ ((m_line % 2) * 2 + (m_col % 2));
        g   = (fmt == 0) ? m_sh[0] : (fmt == 3) ? m_sh[2] : m_sh[1];
        ex_d[k][0] = href ? gained(int'(raw), g) : 0;
        ex_h[k][0] = href;
        ex_v[k][0] = vsync;
      end
      if (vsync && !m_prev_vs) m_sh = '{int'(rg), int'(gg), int'(bg)};
      m_col = href ? m_col + 1 : 0;
      if (vsync) m_line = 0;
      else if (m_prev_href && !href) m_line = m_line + 1;
      m_prev_vs   = vsync;
      m_prev_href = href;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge pclk) begin
    if (chk_en) begin
      chk("href_a",  32'(oh_a), 32'(ex_h[0][2]));
      chk("vsync_a", 32'(ov_a), 32'(ex_v[0][2]));
      chk("raw_a",   32'(or_a), 32'(ex_d[0][2]));
      chk("href_b",  32'(oh_b), 32'(ex_h[1][2]));
      chk("vsync_b", 32'(ov_b), 32'(ex_v[1][2]));
      chk("raw_b",   32'(or_b), 32'(ex_d[1][2]));
    end
  end

  // Valid output pixels, in order, for the literal checks.
  logic [7:0] cap_a[$], cap_b[$];
  always @(negedge pclk) begin
    if (oh_a) cap_a.push_back(or_a);
    if (oh_b) cap_b.push_back(or_b);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit h, input bit v, input logic [7:0] p);
    href = h; vsync = v; raw = p;
    @(negedge pclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  // mode 0 ramp, 1 constant val, 2 random, 3 {200 first, then 3}
  task automatic send_frame(input int w, input int h, input int mode, input int val,
                            input int mid_r);
    drive(1'b0, 1'b1, 8'($urandom));
    drive(1'b0, 1'b1, 8'($urandom));
    idle(2);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        logic [7:0] p;
        case (mode)
          0:       p = 8'(((y * w) + x) * 4);
          1:       p = 8'(val);
          2:       p = 8'($urandom);
          default: p = (x == 0 && y == 0) ? 8'd200 : 8'd3;
        endcase
        drive(1'b1, 1'b0, p);
        if (mid_r >= 0 && y == 0 && x == 1) rg = 8'(mid_r);
      end
      idle(3);
    end
  endtask

  task automatic set_gains(input int r, input int g, input int b);
    rg = 8'(r); gg = 8'(g); bg = 8'(b);
  endtask

  initial begin
    @(negedge pclk);
    // Reset state
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'd55);
    drive(1'b1, 1'b0, 8'd55);
    drive(1'b0, 1'b0, 8'd55);
    chk("reset_href", 32'(oh_a), 32'd0);
    chk("reset_vsync", 32'(ov_a), 32'd0);
    chk("reset_raw", 32'(or_a), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Unity gains: ramp passes through unchanged
    set_gains(64, 64, 64);
    cap_a.delete();
    send_frame(16, 4, 0, 0, -1);
    idle(5);
    chk("ramp_count", 32'(cap_a.size()), 32'd64);
    for (int i = 0; i < 64; i++) chk("ramp_pix", 32'(cap_a[i]), 32'((i * 4) & 255));

    // Per-channel gains on a flat field
    set_gains(128, 64, 32);
    cap_a.delete();
    send_frame(8, 2, 1, 100, -1);
    idle(5);
    chk("flat_count", 32'(cap_a.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      int e;
      if (i < 8) e = (i % 2 == 0) ? 200 : 100;
      else       e = (i % 2 == 0) ? 100 : 50;
      chk("flat_pix", 32'(cap_a[i]), 32'(e));
    end

    // Saturation and round-half-up
    set_gains(255, 96, 64);
    cap_a.delete();
    send_frame(2, 2, 3, 0, -1);
    idle(5);
    chk("saturate", 32'(cap_a[0]), 32'd255);
    chk("round_up", 32'(cap_a[1]), 32'd5);

    // Mid-frame gain write does not take effect until next vsync rise
    set_gains(64, 64, 64);
    cap_a.delete();
    send_frame(4, 2, 1, 100, 128);
    idle(5);
    chk("shadow_hold_r0", 32'(cap_a[0]), 32'd100);
    chk("shadow_hold_r2", 32'(cap_a[2]), 32'd100);
    cap_a.delete();
    send_frame(4, 2, 1, 100, -1);
    idle(5);
    chk("shadow_new_r0", 32'(cap_a[0]), 32'd200);
    chk("shadow_new_g1", 32'(cap_a[1]), 32'd100);

    // Mid-line reset: outputs idle on the next edge, gains back to unity
    drive(1'b0, 1'b1, 8'd0);
    idle(2);
    drive(1'b1, 1'b0, 8'd100);
    drive(1'b1, 1'b0, 8'd100);
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'd100);
    chk("midrst_href", 32'(oh_a), 32'd0);
    chk("midrst_vsync", 32'(ov_a), 32'd0);
    chk("midrst_raw", 32'(or_a), 32'd0);
    rst = 1'b0;
    idle(3);
    cap_a.delete();
    for (int x = 0; x < 4; x++) drive(1'b1, 1'b0, 8'd100);
    idle(5);
    chk("postrst_unity", 32'(cap_a[0]), 32'd100);

    // BAYER=3 channel order
    set_gains(10, 20, 30);
    cap_b.delete();
    send_frame(4, 2, 1, 64, -1);
    idle(5);
    chk("bggr_l0p0", 32'(cap_b[0]), 32'd30);
    chk("bggr_l0p1", 32'(cap_b[1]), 32'd20);
    chk("bggr_l1p0", 32'(cap_b[4]), 32'd20);
    chk("bggr_l1p1", 32'(cap_b[5]), 32'd10);

`ifdef ISP_WBGAIN_STAT_EN
    // Statistics on a 4x2 flat frame of 10s
    send_frame(4, 2, 1, 10, -1);
    idle(3);
    drive(1'b0, 1'b1, 8'd0);
    chk("stat_valid_hi", 32'(sv_a), 32'd1);
    chk("stat_r", sr_a, 32'd20);
    chk("stat_g", sg_a, 32'd40);
    chk("stat_b", sb_a, 32'd20);
    drive(1'b0, 1'b1, 8'd0);
    chk("stat_valid_lo", 32'(sv_a), 32'd0);
    idle(2);
`endif

    // Randomized frames, checked entirely by the model
    for (int f = 0; f < 8; f++) begin
      set_gains(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
      send_frame(int'($urandom_range(2, 12)), int'($urandom_range(1, 4)), 2, 0,
                 (f % 2 == 1) ? int'($urandom_range(0, 255)) : -1);
      idle(int'($urandom_range(1, 4)));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
